// File: rtl/ifu_burst_fetch.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ifu_burst_fetch
//   Instruction-fetch front end. Issues AXI4 INCR read bursts, buffers the
//   returned beats in an instruction FIFO and hands them to decode with a
//   valid/ready handshake. A redirect flushes the FIFO and discards any beats
//   still in flight for the old stream. Only the AR and R channels are used.
//
// Ports
//   clock, reset               single clock, synchronous active-high reset
//   redirect_valid/_pc         flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   inst_valid/_ready          decode handshake on the FIFO head
//   inst_data/_pc/_err         head instruction word, its address, its error flag
//   io_master_ar*              read address channel (burst start, length, constants)
//   io_master_r*               read data channel (rid is ignored)
// ---------------------------------------------------------------------------
module ifu_burst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic [3:0]  io_master_arid,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [31:0] io_master_rdata,
  input  logic [1:0]  io_master_rresp,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Burst length so the burst stops at the next BURST_LEN*4-byte boundary;
  // this also keeps every burst inside one 4KB page.
  function automatic logic [7:0] burst_arlen(input logic [31:0] start_pc);
    logic [31:0] beat_off;
    beat_off = (start_pc >> 2) & (BURST_LEN - 32'd1);
    return 8'(BURST_LEN - 32'd1 - beat_off);
  endfunction

  // Pointer increment with explicit wrap, valid for any depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1'b1);
    end
    return nxt;
  endfunction

  state_e            state_q,    state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       beat_pc_q,  beat_pc_d;
  logic [31:0]       araddr_q,   araddr_d;
  logic [7:0]        arlen_q,    arlen_d;
  logic              discard_q,  discard_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic              err_mem_q  [FIFO_DEPTH];

  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  free_slots_s;
  logic              unused_inputs_s;

  assign unused_inputs_s = ^{io_master_rid, redirect_pc[1:0]};

  // A redirect wins over both push and pop in the same cycle.
  assign push_s       = (state_q == ST_DATA) && io_master_rvalid && !redirect_valid;
  assign pop_s        = (count_q != '0) && inst_ready && !redirect_valid;
  assign free_slots_s = CNT_W'(FIFO_DEPTH) - count_q;

  // Fetch FSM next-state, burst address capture and discard tracking
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    beat_pc_d  = beat_pc_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    discard_d  = discard_q;

    case (state_q)
      ST_IDLE: begin
        // Reserve a full burst of space up front so pushes never see a full FIFO.
        if (!redirect_valid && (free_slots_s >= CNT_W'(BURST_LEN))) begin
          state_d   = ST_ADDR;
          araddr_d  = fetch_pc_q;
          arlen_d   = burst_arlen(fetch_pc_q);
          beat_pc_d = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // araddr/arlen stay frozen until accepted; a redirect only marks the burst stale.
        if (redirect_valid) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (io_master_arready) begin
          if (discard_q || redirect_valid) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (redirect_valid) begin
          // The beat in the redirect cycle is dropped; if it is the last one
          // there is nothing left to drain.
          if (io_master_rvalid && io_master_rlast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (io_master_rvalid) begin
          beat_pc_d = beat_pc_q + 32'd4;
          if (io_master_rlast) begin
            state_d    = ST_IDLE;
            fetch_pc_d = beat_pc_q + 32'd4;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (io_master_rvalid && io_master_rlast) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // FSM, address and FIFO bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      beat_pc_q  <= RESET_PC;
      araddr_q   <= RESET_PC;
      arlen_q    <= 8'd0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      beat_pc_q  <= beat_pc_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; entries are only meaningful while counted in count_q
  always_ff @(posedge clock) begin
    if (push_s) begin
      data_mem_q[wr_ptr_q] <= io_master_rdata;
      pc_mem_q[wr_ptr_q]   <= beat_pc_q;
      err_mem_q[wr_ptr_q]  <= (io_master_rresp != 2'b00);
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_err   = inst_valid & err_mem_q[rd_ptr_q];

  assign io_master_arvalid = (state_q == ST_ADDR);
  assign io_master_araddr  = araddr_q;
  assign io_master_arlen   = arlen_q;
  assign io_master_arsize  = 3'b010;
  assign io_master_arburst = 2'b01;
  assign io_master_arid    = 4'h0;
  assign io_master_rready  = (state_q == ST_DATA) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ifu_burst_fetch.sv
`timescale 1ns/1ps
module tb_ifu_burst_fetch;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
  localparam int BL    = 4;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        io_master_arvalid;
  logic        io_master_arready;
  logic [31:0] io_master_araddr;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst;
  logic [3:0]  io_master_arid;
  logic        io_master_rvalid;
  logic        io_master_rready;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;

  ifu_burst_fetch #(
    .RESET_PC  (RESET_PC),
    .BURST_LEN (BL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .inst_err         (inst_err),
    .io_master_arvalid(io_master_arvalid),
    .io_master_arready(io_master_arready),
    .io_master_araddr (io_master_araddr),
    .io_master_arlen  (io_master_arlen),
    .io_master_arsize (io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_arid   (io_master_arid),
    .io_master_rvalid (io_master_rvalid),
    .io_master_rready (io_master_rready),
    .io_master_rdata  (io_master_rdata),
    .io_master_rresp  (io_master_rresp),
    .io_master_rlast  (io_master_rlast),
    .io_master_rid    (io_master_rid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Slave memory contents and error map, both pure functions of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic beat_err(input logic [31:0] a);
    return ((a >> 2) % 32'd7) == 32'd3;
  endfunction

  // A burst runs from its start address to the next 16-byte boundary.
  function automatic logic [31:0] exp_arlen(input logic [31:0] a);
    return 32'(BL - 1) - ((a >> 2) & 32'(BL - 1));
  endfunction

  // stimulus knobs (percent, redirect in per mille)
  int unsigned ar_prob, r_prob, ready_prob, redir_pm;

  // slave state
  logic [31:0] sq_addr[$];
  int          sq_len[$];
  int          beat;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] next_fetch;
  logic        stale_ar;
  logic        prev_redir;
  logic        prev_ar_wait;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;
  logic        rec_ar_hs, rec_r_hs;
  logic [31:0] rec_araddr;
  logic [7:0]  rec_arlen;
  int          ar_count;
  int          n_pops;
  logic [31:0] last_araddr;

  task automatic model_init();
    exp_pc       = RESET_PC;
    next_fetch   = RESET_PC;
    stale_ar     = 1'b0;
    prev_redir   = 1'b0;
    prev_ar_wait = 1'b0;
    prev_araddr  = 32'd0;
    prev_arlen   = 8'd0;
    rec_ar_hs    = 1'b0;
    rec_r_hs     = 1'b0;
    rec_araddr   = 32'd0;
    rec_arlen    = 8'd0;
    ar_count     = 0;
    n_pops       = 0;
    last_araddr  = 32'd0;
  endtask

  // Observe one cycle (called mid-cycle) and advance the reference model.
  task automatic monitor();
    if (prev_ar_wait) begin
      check_eq("ar_hold_valid", 32'(io_master_arvalid), 32'd1);
      check_eq("ar_hold_addr", io_master_araddr, prev_araddr);
      check_eq("ar_hold_len", 32'(io_master_arlen), 32'(prev_arlen));
    end
    prev_ar_wait = io_master_arvalid && !io_master_arready;
    prev_araddr  = io_master_araddr;
    prev_arlen   = io_master_arlen;

    if (prev_redir) check_eq("flush_valid", 32'(inst_valid), 32'd0);

    if (inst_valid) begin
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst_data", inst_data, mem_word(exp_pc));
      check_eq("inst_err", 32'(inst_err), 32'(beat_err(exp_pc)));
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end

    if (io_master_arvalid && io_master_arready) begin
      ar_count++;
      last_araddr = io_master_araddr;
      check_eq("ar_len", 32'(io_master_arlen), exp_arlen(io_master_araddr));
      check_eq("ar_const", 32'({io_master_arid, io_master_arburst, io_master_arsize}),
               32'({4'h0, 2'b01, 3'b010}));
      if (!stale_ar && !redirect_valid) begin
        check_eq("ar_addr", io_master_araddr, next_fetch);
        next_fetch = next_fetch + 32'd4 * (exp_arlen(next_fetch) + 32'd1);
      end
      stale_ar = 1'b0;
    end

    if (redirect_valid) begin
      exp_pc     = redirect_pc & 32'hFFFF_FFFC;
      next_fetch = exp_pc;
      stale_ar   = io_master_arvalid && !io_master_arready;
    end
    prev_redir = redirect_valid;

    rec_ar_hs  = io_master_arvalid && io_master_arready;
    rec_araddr = io_master_araddr;
    rec_arlen  = io_master_arlen;
    rec_r_hs   = io_master_rvalid && io_master_rready;
  endtask

  // Slave bookkeeping for the edge just passed, then new random inputs.
  task automatic drive();
    logic [31:0] baddr;
    if (rec_ar_hs) begin
      sq_addr.push_back(rec_araddr);
      sq_len.push_back(int'(rec_arlen));
    end
    if (rec_r_hs && sq_addr.size() > 0) begin
      beat++;
      if (beat > sq_len[0]) begin
        void'(sq_addr.pop_front());
        void'(sq_len.pop_front());
        beat = 0;
      end
    end
    io_master_arready = ($urandom_range(0, 99) < ar_prob);
    if (sq_addr.size() > 0 && $urandom_range(0, 99) < r_prob) begin
      baddr            = sq_addr[0] + 32'(4 * beat);
      io_master_rvalid = 1'b1;
      io_master_rdata  = mem_word(baddr);
      io_master_rresp  = beat_err(baddr) ? 2'b10 : 2'b00;
      io_master_rlast  = (beat == sq_len[0]);
    end else begin
      io_master_rvalid = 1'b0;
      io_master_rdata  = $urandom;
      io_master_rresp  = 2'b00;
      io_master_rlast  = 1'b0;
    end
    io_master_rid  = 4'($urandom);
    inst_ready     = ($urandom_range(0, 99) < ready_prob);
    redirect_valid = ($urandom_range(0, 999) < redir_pm);
    redirect_pc    = 32'h3000_0000 | ($urandom & 32'h0000_0FFF);
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset             = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'd0;
    inst_ready        = 1'b0;
    io_master_arready = 1'b0;
    io_master_rvalid  = 1'b0;
    io_master_rdata   = 32'd0;
    io_master_rresp   = 2'b00;
    io_master_rlast   = 1'b0;
    io_master_rid     = 4'h0;
    sq_addr.delete();
    sq_len.delete();
    beat = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_arvalid", 32'(io_master_arvalid), 32'd0);
    check_eq("rst_rready", 32'(io_master_rready), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst_err", 32'(inst_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  int unsigned ar_tab[4]    = '{100, 40, 15, 80};
  int unsigned r_tab[4]     = '{100, 60, 30, 90};
  int unsigned ready_tab[4] = '{100, 50, 70, 30};
  int unsigned redir_tab[4] = '{0, 10, 25, 5};

  initial begin
    int waited;
    int pops_before;
    reset = 1'b1;
    model_init();
    do_reset();

    // Decode stalled: two bursts fill the FIFO, then fetch must stop.
    ar_prob = 100; r_prob = 100; ready_prob = 0; redir_pm = 0;
    repeat (40) step();
    check_eq("stall_ar_count", 32'(ar_count), 32'd2);
    check_eq("stall_arvalid", 32'(io_master_arvalid), 32'd0);
    check_eq("stall_inst_valid", 32'(inst_valid), 32'd1);

    ready_prob = 100;
    repeat (3) step();
    ready_prob = 0;
    repeat (10) step();
    check_eq("three_pops", 32'(n_pops), 32'd3);
    check_eq("no_ar_3free", 32'(ar_count), 32'd2);

    ready_prob = 100;
    step();
    ready_prob = 0;
    waited = 0;
    while (ar_count < 3 && waited < 20) begin
      step();
      waited++;
    end
    check_eq("ar_after_4free", 32'(ar_count), 32'd3);
    check_eq("ar_after_4free_addr", last_araddr, 32'h3000_0020);

    // Randomized phases, each ending in a reset that may land mid-burst.
    for (int ph = 0; ph < 4; ph++) begin
      ar_prob     = ar_tab[ph];
      r_prob      = r_tab[ph];
      ready_prob  = ready_tab[ph];
      redir_pm    = redir_tab[ph];
      pops_before = n_pops;
      repeat (3000) step();
      check_eq("progress", 32'((n_pops - pops_before) > 50), 32'd1);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
